// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizes for the data-memory arbiter slice.
package dmem_arbiter_pkg;
   localparam int DATA_WIDTH           = 32;
   localparam int MEMORY_ADDRESS_WIDTH = 6;
   localparam int DMEM_AW              = MEMORY_ADDRESS_WIDTH + 2;
   localparam int NUM_DMEM_REQ         = 2;

   typedef enum logic {ARB_IDLE, ARB_ACCESS} dmem_arb_state_e;

   typedef struct packed {
      logic                  we;
      logic [DMEM_AW-1:0]    addr;
      logic [DATA_WIDTH-1:0] wdata;
   } dmem_req_t;
endpackage

// File: rtl/dmem_arbiter_arb_picker.sv
// Combinational one-hot picker: first valid requester found searching upward
// (with wrap) from the start pointer.
module arb_picker #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] win
);
   int idx;

   // Walk from the farthest offset down so the nearest valid to ptr is the final assignment.
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (valid[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            win        = PW'(idx);
         end
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-phase (IDLE/ACCESS) arbiter sharing one data_memory port among NUM_REQ requesters.
// Define DMEM_ARB_RR_EN for round-robin; otherwise lowest index (the core) wins.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_DMEM_REQ,
   parameter int AW      = DMEM_AW,
   parameter int DW      = DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memory_ok,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_write_en,
   output logic [AW-1:0]         mem_address,
   output logic [DW-1:0]         mem_write_data,
   input  logic [DW-1:0]         mem_read_data
);
   localparam int PW = $clog2(NUM_REQ);

   dmem_arb_state_e    state;
   dmem_req_t          lat;
   logic [PW-1:0]      owner, ptr, win;
   logic [NUM_REQ-1:0] grant;
   logic               take, misaligned;

   arb_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .win   (win)
   );

`ifdef DMEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst)       ptr <= '0;
      else if (take) ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
   end
`else
   assign ptr = '0;
`endif

   assign take       = (state == ARB_IDLE) & memory_ok & ~rst & (|req_valid);
   assign req_ready  = take ? grant : '0;
   assign misaligned = (lat.addr[1:0] != 2'b00);

   // The latch only changes on a grant, so it doubles as the held memory-side address/data.
   assign mem_address    = lat.addr;
   assign mem_write_data = lat.wdata;
   assign mem_write_en   = (state == ARB_ACCESS) & lat.we & ~misaligned & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         lat       <= '0;
         owner     <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (take) begin
                  lat   <= '{we:    req_we[win],
                             addr:  req_addr[win*AW +: AW],
                             wdata: req_wdata[win*DW +: DW]};
                  owner <= win;
                  state <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               rsp_valid <= NUM_REQ'(1) << owner;
               rsp_err   <= misaligned;
               rsp_rdata <= (lat.we | misaligned) ? '0 : mem_read_data;
               state     <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a cycle-scheduled reference model.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;
   localparam int N = 2, AW = DMEM_AW, DW = DATA_WIDTH, WORDS = 1 << MEMORY_ADDRESS_WIDTH;

   logic clk = 1'b0, rst, memory_ok;
   logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_write_data, mem_read_data;
   logic            rsp_err, mem_write_en;
   logic [AW-1:0]   mem_address;
   logic [DW-1:0]   mem [WORDS];
   int              we_cnt = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst(rst), .memory_ok(memory_ok),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   // data_memory stand-in: combinational read, write on posedge
   assign mem_read_data = mem[mem_address[AW-1:2]];
   always @(posedge clk) begin
      if (mem_write_en === 1'b1) begin
         mem[mem_address[AW-1:2]] <= mem_write_data;
         we_cnt <= we_cnt + 1;
      end
   end

   // reference model: accept at cycle c -> access at c+1 -> response visible at c+2
   int              total = 0, bad = 0, cyc = 0;
   logic [DW-1:0]   ref_mem [WORDS];
   int              free_cyc = 0, ptr_m = 0;
   bit              p_act, p_we;
   int              p_own, p_cyc;
   logic [AW-1:0]   p_addr;
   logic [DW-1:0]   p_wd;
   bit              r_act, r_err;
   int              r_own, r_cyc;
   logic [DW-1:0]   r_data;
   bit              hold [N];
   logic [N-1:0]    got_ready;
   int              wins[$];

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int pick(logic [N-1:0] v);
`ifdef DMEM_ARB_RR_EN
      for (int k = 0; k < N; k++) if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
`else
      for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
      return -1;
   endfunction

   task automatic issue(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic rand_req(int i, bit allow_we);
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(i, allow_we && ($urandom_range(0, 1) == 1), a, $urandom);
   endtask

   task automatic step();
      logic [N-1:0] e_rdy;
      int           w;
      bit           e_we, mis;
      #1;
      w = (!rst && memory_ok && cyc >= free_cyc) ? pick(req_valid) : -1;
      e_rdy = '0;
      if (w >= 0) e_rdy[w] = 1'b1;
      chk("req_ready", req_ready, e_rdy);
      e_we = !rst && p_act && cyc == p_cyc && p_we && p_addr[1:0] == 2'b00;
      chk("mem_write_en", mem_write_en, e_we);
      if (p_act && cyc == p_cyc) begin
         chk("mem_address", mem_address, p_addr);
         if (p_we) chk("mem_write_data", mem_write_data, p_wd);
      end
      if (r_act && cyc == r_cyc) begin
         chk("rsp_valid", rsp_valid, N'(1) << r_own);
         chk("rsp_rdata", rsp_rdata, r_data);
         chk("rsp_err", rsp_err, r_err);
      end else chk("rsp_idle", rsp_valid, 0);
      got_ready = req_ready;
      if (rst) begin
         p_act = 0; r_act = 0; ptr_m = 0; free_cyc = cyc + 1;
      end else begin
         if (p_act && cyc == p_cyc) begin
            mis    = (p_addr[1:0] != 2'b00);
            r_act  = 1; r_cyc = cyc + 1; r_own = p_own; r_err = mis;
            r_data = (p_we || mis) ? '0 : ref_mem[p_addr >> 2];
            if (p_we && !mis) ref_mem[p_addr >> 2] = p_wd;
            p_act  = 0;
         end
         if (w >= 0) begin
            p_act = 1; p_cyc = cyc + 1; p_own = w; p_we = req_we[w];
            p_addr = req_addr[w*AW +: AW]; p_wd = req_wdata[w*DW +: DW];
            free_cyc = cyc + 2; ptr_m = (w + 1) % N;
            wins.push_back(w);
         end
      end
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++)
         if (got_ready[i]) begin
            if (hold[i]) rand_req(i, 1'b0);
            else req_valid[i] = 1'b0;
         end
   endtask

   task automatic wait_grant(int i);
      for (int n = 0; n < 40; n++) begin
         step();
         if (got_ready[i]) return;
      end
      chk("grant_seen", got_ready[i], 1);
   endtask

   initial begin
      int wc;
      for (int k = 0; k < WORDS; k++) begin
         mem[k] = $urandom; ref_mem[k] = mem[k];
      end
      rst = 1'b1; memory_ok = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      hold[0] = 0; hold[1] = 0;
      @(posedge clk); #1;
      step(); step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mem_we", mem_write_en, 0);
      chk("rst_mem_addr", mem_address, 0);
      chk("rst_mem_wdata", mem_write_data, 0);
      rst = 1'b0;
      step();

      // 1: read of a preloaded word
      mem[3] = 32'hDEAD_BEEF; ref_mem[3] = 32'hDEAD_BEEF;
      issue(0, 0, 8'h0C, '0);
      step();
      chk("t1_ready0", got_ready, 2'b01);
      step();
      chk("t1_rsp_valid", rsp_valid, 2'b01);
      chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_err", rsp_err, 0);
      step();

      // 2: debug port write then read back
      wc = we_cnt;
      issue(1, 1, 8'h10, 32'h1234_5678);
      step(); step();
      chk("t2_one_write", we_cnt - wc, 1);
      issue(1, 0, 8'h10, '0);
      step(); step();
      chk("t2_rsp_valid", rsp_valid, 2'b10);
      chk("t2_rdata", rsp_rdata, 32'h1234_5678);

      // 3: both requesters held valid
      hold[0] = 1; hold[1] = 1;
      rand_req(0, 1'b0); rand_req(1, 1'b0);
      wins.delete();
      for (int n = 0; n < 40 && wins.size() < 8; n++) step();
      chk("t3_grants", wins.size() >= 8, 1);
      for (int k = 0; k < 8 && k < wins.size(); k++)
`ifdef DMEM_ARB_RR_EN
         chk("t3_rr_order", wins[k], k % 2);
`else
         chk("t3_fixed_order", wins[k], 0);
`endif
      hold[0] = 0; hold[1] = 0;
      for (int n = 0; n < 20 && req_valid != '0; n++) step();
      chk("t3_drained", req_valid, 0);
`ifndef DMEM_ARB_RR_EN
      chk("t3_req1_after_drop", wins[$], 1);
`endif
      step(); step();

      // 4: misaligned write must not touch memory
      wc = we_cnt;
      issue(0, 1, 8'h0D, 32'hFFFF_FFFF);
      step(); step();
      chk("t4_rsp_valid", rsp_valid, 2'b01);
      chk("t4_err", rsp_err, 1);
      chk("t4_rdata", rsp_rdata, 0);
      chk("t4_no_write", we_cnt - wc, 0);
      chk("t4_word3", mem[3], 32'hDEAD_BEEF);
      step();

      // 5: memory_ok low blocks grants
      memory_ok = 1'b0;
      issue(0, 0, 8'h0C, '0);
      for (int n = 0; n < 5; n++) begin
         step();
         chk("t5_blocked", got_ready, 0);
      end
      memory_ok = 1'b1;
      step();
      chk("t5_grant", got_ready, 2'b01);
      step(); step();

      // 6: reset lands on the ACCESS cycle of a write
      mem[5] = 32'h0000_5555; ref_mem[5] = 32'h0000_5555;
      issue(0, 1, 8'h14, 32'hA5A5_A5A5);
      wait_grant(0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_word5", mem[5], 32'h0000_5555);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_rsp_rdata", rsp_rdata, 0);
      chk("t6_rsp_err", rsp_err, 0);
      chk("t6_mem_addr", mem_address, 0);
      chk("t6_mem_wdata", mem_write_data, 0);
      chk("t6_mem_we", mem_write_en, 0);
      step();

      // random traffic
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i, 1'b1);
         memory_ok = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; memory_ok = 1'b1; req_valid = '0;
      step(); step(); step();
      for (int k = 0; k < WORDS; k++) chk("final_mem", mem[k], ref_mem[k]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
